// File: rtl/mux_pipe_stage.sv
// CH-way select into a registered output stage with valid/ready handshake and
// a one-entry skid buffer, so upstream can run at full rate under back-pressure.
//
// state | meaning
// EMPTY | no entry held: out_valid=0, in_ready=1
// HALF  | main holds an entry, skid empty: out_valid=1, in_ready=1
// FULL  | main and skid both hold entries: out_valid=1, in_ready=0
module mux_pipe_stage #(
    parameter int N    = 32,
    parameter int CH   = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [SELW-1:0] sel,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sel_err,
    input  logic            sel_err_clr
);

    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    localparam logic [SELW:0] CH_LIM = (SELW + 1)'(CH);

    state_t         state;
    logic [N-1:0]   skid_data;
    logic [N-1:0]   sel_data;
    logic           sel_ok;
    logic           accept;
    logic           drain;

    assign sel_ok = {1'b0, sel} < CH_LIM;
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // An out-of-range select matches no channel and so yields all-zero data.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if ({1'b0, sel} == (SELW + 1)'(k)) begin
                sel_data = in_data[k*N +: N];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            skid_data <= '0;
            sel_err   <= 1'b0;
        end else begin
            // Flush kills entries but not the error record of a killed accept.
            if (accept && !sel_ok) begin
                sel_err <= 1'b1;
            end else if (sel_err_clr) begin
                sel_err <= 1'b0;
            end

            if (flush) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            out_data  <= sel_data;
                            out_valid <= 1'b1;
                            state     <= HALF;
                        end
                    end
                    HALF: begin
                        if (accept && drain) begin
                            out_data <= sel_data;
                        end else if (accept) begin
                            skid_data <= sel_data;
                            in_ready  <= 1'b0;
                            state     <= FULL;
                        end else if (drain) begin
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (drain) begin
                            out_data <= skid_data;
                            in_ready <= 1'b1;
                            state    <= HALF;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Scoreboard bench: a 4-channel and a 3-channel stage share one stimulus stream;
// each has its own expected-output queue and sticky-error model.
module tb_mux_pipe_stage;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  in_data;
    logic [1:0]    sel;
    logic          in_valid;
    logic          flush;
    logic          out_ready;
    logic          sel_err_clr;

    logic          ir4, ov4, se4;
    logic [31:0]   od4;
    logic          ir3, ov3, se3;
    logic [31:0]   od3;

    int            n_checks = 0;
    int            n_fail   = 0;

    logic [31:0]   q4[$];
    logic [31:0]   q3[$];
    logic          pushed[2];
    logic          exp_err[2];
    logic          err_next[2];
    logic          pv_stall[2];
    logic [31:0]   pv_data[2];

    mux_pipe_stage #(.N(32), .CH(4), .SELW(2)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(ir4), .flush(flush), .out_data(od4), .out_valid(ov4),
        .out_ready(out_ready), .sel_err(se4), .sel_err_clr(sel_err_clr)
    );

    mux_pipe_stage #(.N(32), .CH(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[95:0]), .sel(sel), .in_valid(in_valid),
        .in_ready(ir3), .flush(flush), .out_data(od3), .out_valid(ov3),
        .out_ready(out_ready), .sel_err(se3), .sel_err_clr(sel_err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: channel s of the packed word, or zero when s names no channel.
    function automatic logic [31:0] ref_sel(input int ch, input logic [1:0] s, input logic [127:0] d);
        if (int'(s) < ch) return d[int'(s)*32 +: 32];
        return 32'h0;
    endfunction

    function automatic logic [127:0] pack4(input logic [31:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    task automatic clear_model();
        q4.delete();
        q3.delete();
        for (int i = 0; i < 2; i++) begin
            pushed[i]   = 1'b0;
            exp_err[i]  = 1'b0;
            err_next[i] = 1'b0;
            pv_stall[i] = 1'b0;
            pv_data[i]  = 32'h0;
        end
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic drive(input logic iv, input logic [1:0] s, input logic orr,
                         input logic fl, input logic clr, input logic [127:0] d);
        logic acc;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_err[i] = err_next[i];
            pushed[i]  = 1'b0;
        end
        in_valid    = iv;
        sel         = s;
        out_ready   = orr;
        flush       = fl;
        sel_err_clr = clr;
        in_data     = d;

        acc = iv & ir4;
        if (acc && !fl) begin
            q4.push_back(ref_sel(4, s, d));
            pushed[0] = 1'b1;
        end
        err_next[0] = (acc && int'(s) >= 4) ? 1'b1 : (clr ? 1'b0 : exp_err[0]);

        acc = iv & ir3;
        if (acc && !fl) begin
            q3.push_back(ref_sel(3, s, d));
            pushed[1] = 1'b1;
        end
        err_next[1] = (acc && int'(s) >= 3) ? 1'b1 : (clr ? 1'b0 : exp_err[1]);
    endtask

    task automatic idle(input int n, input logic orr);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, orr, 1'b0, 1'b0, 128'h0);
    endtask

    task automatic mon(input int id, input logic ov, input logic ir,
                       input logic [31:0] od, input logic se);
        int          sz;
        int          occ;
        logic [31:0] front;
        sz    = (id == 0) ? q4.size() : q3.size();
        front = 32'h0;
        if (sz > 0) front = (id == 0) ? q4[0] : q3[0];
        occ = sz - (pushed[id] ? 1 : 0);

        chk(id == 0 ? "out_valid4" : "out_valid3", {31'h0, ov}, {31'h0, occ > 0});
        chk(id == 0 ? "in_ready4" : "in_ready3", {31'h0, ir}, {31'h0, occ < 2});
        chk(id == 0 ? "sel_err4" : "sel_err3", {31'h0, se}, {31'h0, exp_err[id]});
        if (ov && occ > 0) chk(id == 0 ? "out_data4" : "out_data3", od, front);
        if (pv_stall[id]) begin
            chk(id == 0 ? "stable_data4" : "stable_data3", od, pv_data[id]);
            chk(id == 0 ? "stable_valid4" : "stable_valid3", {31'h0, ov}, 32'h1);
        end

        pv_stall[id] = ov & ~out_ready & ~flush;
        pv_data[id]  = od;
        if (ov && out_ready && occ > 0) begin
            if (id == 0) void'(q4.pop_front());
            else         void'(q3.pop_front());
        end
        if (flush) begin
            if (id == 0) q4.delete();
            else         q3.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov4, ir4, od4, se4);
            mon(1, ov3, ir3, od3, se3);
        end
    end

    logic [127:0] abcd;
    logic [127:0] rnd;

    initial begin
        rst = 1'b1;
        in_data = '0; sel = '0; in_valid = 1'b0; flush = 1'b0;
        out_ready = 1'b0; sel_err_clr = 1'b0;
        clear_model();
        #2;
        chk("rst_out_valid", {31'h0, ov4}, 32'h0);
        chk("rst_in_ready", {31'h0, ir4}, 32'h1);
        chk("rst_out_data", od4, 32'h0);
        chk("rst_sel_err", {31'h0, se4}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        abcd = pack4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

        // Single accept then a back-to-back sweep of every select value.
        drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, abcd);
        for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), 1'b1, 1'b0, 1'b0, abcd);
        idle(2, 1'b1);

        // Back-pressure: A and B stack up, then drain in order.
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, abcd);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, abcd);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, abcd);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Out-of-range select on the 3-channel stage, clear, then set-beats-clear.
        drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, abcd);
        idle(1, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, abcd);
        idle(1, 1'b1);
        drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, abcd);
        idle(2, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, abcd);

        // Flush from FULL with a simultaneous offer (out-of-range on the 3-ch stage).
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, abcd);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, abcd);
        drive(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, abcd);
        idle(3, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, abcd);

        // Asynchronous reset in the middle of a cycle while FULL.
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, abcd);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, abcd);
        idle(1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'h0, ov4}, 32'h0);
        chk("arst_in_ready", {31'h0, ir4}, 32'h1);
        chk("arst_out_data", od4, 32'h0);
        chk("arst_sel_err3", {31'h0, se3}, 32'h0);
        clear_model();
        #1 rst = 1'b0;
        idle(2, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 10000; c++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 19) == 0), rnd);
        end
        idle(4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
